// File: rtl/uart_rx.sv
// UART receiver: two-FF synchroniser plus edge detect, mid-bit sampling.
// Frame = start (low), DATA_BIT data bits LSB first, STOP_BIT stop bits (high).
module uart_rx #(
    parameter int DATA_BIT = 8,
    parameter int STOP_BIT = 1,
    parameter int BPS_MAX  = 9600
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    // rx_valid / rx_frame_err are single-cycle strobes with no ready: there is
    // no backpressure, so the consumer must take rx_data in the rx_valid cycle.
    output logic [DATA_BIT-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_frame_err,
    output logic                rx_busy
);

    localparam logic [25:0] MID_CNT   = 26'(BPS_MAX / 2 - 1);
    localparam logic [25:0] END_CNT   = 26'(BPS_MAX - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BIT - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                s1;
    logic                s2;
    logic                s3;
    logic [25:0]         bps_cnt;
    logic [3:0]          bit_cnt;
    logic [DATA_BIT-1:0] shift_reg;
    logic                stop_ok;
    logic                fall;
    logic                at_mid;
    logic                at_end;
    logic                frame_done;
    logic                frame_good;

    // Reset to 0 so a line held low through reset is not taken as a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall   = s3 & ~s2;
    assign at_mid = (bps_cnt == MID_CNT);
    assign at_end = (bps_cnt == END_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        frame_good = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                if (at_mid && s2) state_nxt = IDLE;
                else if (at_end)  state_nxt = DATA;
            end
            DATA: begin
                if (at_end && bit_cnt == DATA_LAST) state_nxt = STOP;
            end
            STOP: begin
                // Leave at the mid of the last stop bit so a start bit that
                // immediately follows is still seen as a falling edge.
                if (at_mid && bit_cnt == STOP_LAST) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                    frame_good = stop_ok & s2;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bps_cnt <= '0;
            bit_cnt <= '0;
        end else if (state_nxt != state || state == IDLE) begin
            bps_cnt <= '0;
            bit_cnt <= '0;
        end else if (at_end) begin
            bps_cnt <= '0;
            bit_cnt <= bit_cnt + 4'd1;
        end else begin
            bps_cnt <= bps_cnt + 26'd1;
        end
    end

    // Right shift: after DATA_BIT samples the first bit sits at the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            stop_ok   <= 1'b0;
        end else begin
            if (state == DATA && at_mid) begin
                shift_reg <= {s2, shift_reg[DATA_BIT-1:1]};
            end
            if (state_nxt == STOP && state != STOP) begin
                stop_ok <= 1'b1;
            end else if (state == STOP && at_mid) begin
                stop_ok <= stop_ok & s2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= frame_done & frame_good;
            rx_frame_err <= frame_done & ~frame_good;
            if (frame_done && frame_good) begin
                rx_data <= shift_reg;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames and random traffic on an 8N1/16 instance,
// plus a 7-bit / 2-stop / 17-cycle instance driven with every 7-bit value.
module tb_uart_rx;

    localparam int A_BPS = 16;
    localparam int B_BPS = 17;
    localparam int A_LAT = 2 + (1 + 8 + 1 - 1) * A_BPS + (A_BPS / 2 - 1) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_a;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ferr_a;
    logic       busy_a;
    logic       rx_b;
    logic [6:0] data_b;
    logic       valid_b;
    logic       ferr_b;
    logic       busy_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cnt_a = 0;
    int ferr_cnt_a = 0;
    int busy_cyc_a = 0;
    int valid_cnt_b = 0;
    int ferr_cnt_b = 0;
    int t_fall_a = 0;
    int t_valid_a = 0;
    int exp_valid_a = 0;
    int exp_ferr_a = 0;

    logic [7:0] exp_q_a[$];
    logic [6:0] exp_q_b[$];

    uart_rx #(.DATA_BIT(8), .STOP_BIT(1), .BPS_MAX(A_BPS)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_frame_err(ferr_a), .rx_busy(busy_a)
    );

    uart_rx #(.DATA_BIT(7), .STOP_BIT(2), .BPS_MAX(B_BPS)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b),
        .rx_valid(valid_b), .rx_frame_err(ferr_b), .rx_busy(busy_b)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every rx_valid pops the oldest expected word
    always @(negedge clk) begin
        if (rst) begin
            if (valid_a) begin
                valid_cnt_a++;
                t_valid_a = cyc;
                check("a_valid_expected", 32'(exp_q_a.size() != 0), 32'd1);
                if (exp_q_a.size() != 0) check("a_data", 32'(data_a), 32'(exp_q_a.pop_front()));
                check("a_valid_ferr_exclusive", 32'(ferr_a), 32'd0);
            end
            if (ferr_a) ferr_cnt_a++;
            if (busy_a) busy_cyc_a++;
            if (valid_b) begin
                valid_cnt_b++;
                check("b_valid_expected", 32'(exp_q_b.size() != 0), 32'd1);
                if (exp_q_b.size() != 0) check("b_data", 32'(data_b), 32'(exp_q_b.pop_front()));
            end
            if (ferr_b) ferr_cnt_b++;
        end
    end

    // Ideal serial drivers; called and returning on a falling clock edge
    task automatic send_a(input logic [7:0] d, input logic stop_v);
        rx_a = 1'b0;
        t_fall_a = cyc;
        repeat (A_BPS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            repeat (A_BPS) @(negedge clk);
        end
        rx_a = stop_v;
        repeat (A_BPS) @(negedge clk);
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [6:0] d);
        rx_b = 1'b0;
        repeat (B_BPS) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx_b = d[i];
            repeat (B_BPS) @(negedge clk);
        end
        rx_b = 1'b1;
        repeat (2 * B_BPS) @(negedge clk);
    endtask

    logic [7:0] t2_words[3] = '{8'h00, 8'hFF, 8'h55};
    logic [7:0] d5 = 8'hC3;

    initial begin
        int b0;
        int lat;
        logic [7:0] d;
        logic bad;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_a", 32'(data_a), 32'd0);
        check("reset_valid_a", 32'(valid_a), 32'd0);
        check("reset_ferr_a", 32'(ferr_a), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_data_b", 32'(data_b), 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame and latency
        exp_q_a.push_back(8'hA5); exp_valid_a++;
        send_a(8'hA5, 1'b1);
        repeat (24) @(negedge clk);
        check("t1_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));
        check("t1_ferr_count", 32'(ferr_cnt_a), 32'd0);
        check("t1_busy_after", 32'(busy_a), 32'd0);
        check("t1_data", 32'(data_a), 32'hA5);
        lat = t_valid_a - t_fall_a;
        check("t1_latency_in_window", 32'(lat >= A_LAT - 1 && lat <= A_LAT + 1), 32'd1);

        // Back-to-back frames, no idle gap
        for (int i = 0; i < 3; i++) begin
            exp_q_a.push_back(t2_words[i]); exp_valid_a++;
            send_a(t2_words[i], 1'b1);
        end
        repeat (24) @(negedge clk);
        check("t2_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));
        check("t2_ferr_count", 32'(ferr_cnt_a), 32'd0);
        check("t2_data_last", 32'(data_a), 32'h55);

        // Short low glitch is rejected
        b0 = busy_cyc_a;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_busy_short", 32'((busy_cyc_a - b0) > 0 && (busy_cyc_a - b0) < 16), 32'd1);
        check("t3_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));
        check("t3_ferr_count", 32'(ferr_cnt_a), 32'd0);
        exp_q_a.push_back(8'h12); exp_valid_a++;
        send_a(8'h12, 1'b1);
        repeat (24) @(negedge clk);
        check("t3_after_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));
        check("t3_after_data", 32'(data_a), 32'h12);

        // Bad stop bit followed by a stuck-low line
        send_a(8'h3C, 1'b0); exp_ferr_a++;
        rx_a = 1'b0;
        b0 = busy_cyc_a;
        repeat (40 * A_BPS) @(negedge clk);
        check("t4_idle_while_low", 32'(busy_cyc_a - b0), 32'd0);
        check("t4_ferr_count", 32'(ferr_cnt_a), 32'(exp_ferr_a));
        check("t4_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));
        check("t4_data_held", 32'(data_a), 32'h12);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        exp_q_a.push_back(8'h7E); exp_valid_a++;
        send_a(8'h7E, 1'b1);
        repeat (24) @(negedge clk);
        check("t4_after_data", 32'(data_a), 32'h7E);
        check("t4_after_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));

        // Reset during data bit 4
        rx_a = 1'b0;
        repeat (A_BPS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = d5[i];
            repeat (A_BPS) @(negedge clk);
        end
        rx_a = d5[4];
        repeat (A_BPS / 2) @(negedge clk);
        check("t5_busy_mid_frame", 32'(busy_a), 32'd1);
        rst = 1'b0;
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_data", 32'(data_a), 32'd0);
        check("t5_rst_valid", 32'(valid_a), 32'd0);
        check("t5_rst_ferr", 32'(ferr_a), 32'd0);
        check("t5_rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        exp_q_a.push_back(8'h81); exp_valid_a++;
        send_a(8'h81, 1'b1);
        repeat (24) @(negedge clk);
        check("t5_data", 32'(data_a), 32'h81);
        check("t5_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));

        // Random traffic: random words, gaps, occasional bad stop bit
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            if (bad) begin
                exp_ferr_a++;
            end else begin
                exp_q_a.push_back(d); exp_valid_a++;
            end
            send_a(d, !bad);
            repeat (bad ? $urandom_range(3, 20) : $urandom_range(0, 20)) @(negedge clk);
        end
        repeat (24) @(negedge clk);
        check("rand_valid_count", 32'(valid_cnt_a), 32'(exp_valid_a));
        check("rand_ferr_count", 32'(ferr_cnt_a), 32'(exp_ferr_a));
        check("rand_queue_drained", 32'(exp_q_a.size()), 32'd0);

        // 7-bit, 2 stop bits, odd bit period: every value back-to-back
        for (int v = 0; v < 128; v++) begin
            exp_q_b.push_back(7'(v));
            send_b(7'(v));
        end
        repeat (30) @(negedge clk);
        check("t6_valid_count", 32'(valid_cnt_b), 32'd128);
        check("t6_ferr_count", 32'(ferr_cnt_b), 32'd0);
        check("t6_queue_drained", 32'(exp_q_b.size()), 32'd0);
        check("t6_data_last", 32'(data_b), 32'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive stage that deserialises an asynchronous serial line, such as the output of the team's UART transmitter, into parallel words.
- Frame format: 1 start bit (low), DATA_BIT data bits LSB first, STOP_BIT stop bits (high).
- Uses the same BPS_MAX bit-period convention as the transmitter and samples at mid-bit.
- Delivers each word with a one-cycle valid pulse and flags framing errors.

Parameters:
DATA_BIT, 8, data bits per frame; legal 5..15.
STOP_BIT, 1, stop bits per frame; legal 1..2.
BPS_MAX, 9600, clk cycles per bit period; legal 4..2^26-1.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-low.
rx  input  1  serial line, asynchronous to clk, idles high.
rx_data  output  DATA_BIT  last correctly framed word, LSB = first received data bit.
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low; frame discarded.
rx_busy  output  1  high whenever the state machine is not IDLE.

Behaviour:
- Clock and reset: clk is the clock. rst is asynchronous, active-low.
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0, state=IDLE, all counters 0.
- Synchroniser: rx passes through 2 FFs (s1, s2), then a 3rd FF (s3) for edge detect. All three reset to 0.
- Falling edge = s3==1 && s2==0. Input-to-detect latency is 2 clk.
- Consequence of the 0 reset value: a line held low through reset release is not seen as a start. The line must be seen high first.
- Counters: bps_cnt is 26 bits and counts 0..BPS_MAX-1 in every non-IDLE state. bit_cnt is 4 bits and counts bits within the current state; both clear on every state change.
- MID = BPS_MAX/2 - 1 (integer division). "Sample" means capture s2 on the clk edge where bps_cnt==MID.
- State IDLE:
  - bps_cnt and bit_cnt held at 0.
  - Falling edge → START.
- State START:
  - Sample at MID. If the sample is 1, it is a glitch: → IDLE immediately, with no output pulse.
  - Otherwise → DATA at bps_cnt==BPS_MAX-1.
- State DATA:
  - At each MID, shift_reg[bit_cnt] <= s2.
  - At each bps_cnt==BPS_MAX-1, bit_cnt++.
  - → STOP at end of bit DATA_BIT-1.
- State STOP:
  - At each MID, AND the sample into a stop_ok flag, which is set to 1 on entry.
  - At the MID of stop bit STOP_BIT-1 → IDLE. The state exits here, not at the end of the bit, so back-to-back frames with zero idle gap are caught.
  - On that same edge: if stop_ok after including the final sample, then rx_data <= shift_reg and rx_valid=1 for exactly one cycle.
  - Otherwise rx_frame_err=1 for one cycle and rx_data is held.
  - rx_valid and rx_frame_err are never high together.
- Overall latency: rx_valid rises 2 + (1 + DATA_BIT + STOP_BIT - 1)*BPS_MAX + MID + 1 clk after the start-bit falling edge on rx, within ±1 clk of the synchroniser.
- Break / stuck-low line: after a framing error the block sits in IDLE. No new start is accepted until the line has been high for ≥1 synchronised cycle.
- Reset mid-frame: all state and outputs return to reset values and the partial frame is lost. The next start requires a high-to-low transition after reset.
- rx_busy is combinational from the state (state != IDLE).
- No internal FIFO: rx_data is overwritten by each good frame and the consumer must capture it on the rx_valid pulse.

Test Plan:
1. BPS_MAX=16; drive frame 0xA5 from an ideal driver → exactly one rx_valid pulse, rx_data=0xA5, rx_frame_err never high, rx_busy low after the pulse.
2. BPS_MAX=16; drive 0x00, 0xFF, 0x55 back-to-back with zero idle between stop and next start → three rx_valid pulses with rx_data 0x00, 0xFF, 0x55 in order, no frame errors.
3. Idle line; pulse rx low for 3 clk (< MID+2) → rx_busy high for less than 16 clk, then IDLE; no rx_valid, no rx_frame_err; a following frame 0x12 is received correctly.
4. Frame 0x3C with its stop bit driven low, line then held low for 40 bit times → one rx_frame_err pulse, no rx_valid, rx_data keeps the prior value 0x12. No further activity until the line returns high; a subsequent frame 0x7E is received.
5. Assert rst during DATA bit 4 of frame 0xC3, release with the line high → all outputs 0 during reset, no pulse for 0xC3; the next frame 0x81 gives rx_data=0x81.
6. Loopback with the team's UART transmitter at DATA_BIT=7, STOP_BIT=2, BPS_MAX=17 (odd); send 0x00..0x7F → 128 rx_valid pulses matching in order, zero frame errors.
